// File: rtl/imm_encoder.sv
// imm_encoder: range-checks a 32-bit immediate against an instruction format and
// scatters its bits into a base instruction word, through a two-stage valid/ready pipe.
module imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_imm_src,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] SRC_I = 3'd0;
  localparam logic [2:0] SRC_S = 3'd1;
  localparam logic [2:0] SRC_B = 3'd2;
  localparam logic [2:0] SRC_J = 3'd3;
  localparam logic [2:0] SRC_U = 3'd4;

  logic        s1_valid;
  logic [31:0] s1_field;
  logic [31:0] s1_mask;
  logic [31:0] s1_base;
  logic        s1_err;
  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;
  logic        s1_adv;

  logic [31:0] field;
  logic [31:0] mask;
  logic        fits;

  assign s1_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  // A value fits an N-bit signed field when all bits above the field's sign bit match it.
  always_comb begin
    field = '0;
    mask  = '0;
    fits  = 1'b0;
    case (in_imm_src)
      SRC_I: begin
        fits         = (&in_imm[31:11]) || !(|in_imm[31:11]);
        field[31:20] = in_imm[11:0];
        mask         = 32'hFFF0_0000;
      end
      SRC_S: begin
        fits         = (&in_imm[31:11]) || !(|in_imm[31:11]);
        field[31:25] = in_imm[11:5];
        field[11:7]  = in_imm[4:0];
        mask         = 32'hFE00_0F80;
      end
      SRC_B: begin
        fits         = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
        field[31]    = in_imm[12];
        field[30:25] = in_imm[10:5];
        field[11:8]  = in_imm[4:1];
        field[7]     = in_imm[11];
        mask         = 32'hFE00_0F80;
      end
      SRC_J: begin
        fits         = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
        field[31]    = in_imm[20];
        field[30:21] = in_imm[10:1];
        field[20]    = in_imm[11];
        field[19:12] = in_imm[19:12];
        mask         = 32'hFFFF_F000;
      end
      SRC_U: begin
        fits         = !(|in_imm[11:0]);
        field[31:12] = in_imm[31:12];
        mask         = 32'hFFFF_F000;
      end
      default: begin
        fits = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_field <= '0;
      s1_mask  <= '0;
      s1_base  <= '0;
      s1_err   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_field <= field;
        s1_mask  <= mask;
        s1_base  <= in_base;
        s1_err   <= !fits;
      end
    end
  end

  // Stage 2 holds its word while the consumer stalls, which keeps out_* stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= (s1_base & ~s1_mask) | (s1_field & s1_mask);
        s2_err   <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && !(&err_count)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign out_valid = s2_valid;
  assign out_instr = s2_instr;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard bench for imm_encoder; a reference encoder/extender
// written from the format rules predicts every emitted word and the error count.
module tb_imm_encoder;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  src;
    logic [31:0] imm;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_imm_src;
  logic [31:0]          in_imm;
  logic [31:0]          in_base;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  logic [ERR_CNT_W-1:0] modelCnt = '0;
  bit   randReady = 0;

  imm_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm_src(in_imm_src), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base);
    exp_t e;
    int   s;
    s = int'(imm);
    e.instr = base;
    e.src = src;
    e.imm = imm;
    case (src)
      3'd0: begin
        e.err = !(s >= -2048 && s <= 2047);
        e.instr[31:20] = imm[11:0];
      end
      3'd1: begin
        e.err = !(s >= -2048 && s <= 2047);
        e.instr[31:25] = imm[11:5];
        e.instr[11:7] = imm[4:0];
      end
      3'd2: begin
        e.err = !(s >= -4096 && s <= 4094 && imm[0] == 1'b0);
        e.instr[31] = imm[12];
        e.instr[30:25] = imm[10:5];
        e.instr[11:8] = imm[4:1];
        e.instr[7] = imm[11];
      end
      3'd3: begin
        e.err = !(s >= -1048576 && s <= 1048574 && imm[0] == 1'b0);
        e.instr[31] = imm[20];
        e.instr[30:21] = imm[10:1];
        e.instr[20] = imm[11];
        e.instr[19:12] = imm[19:12];
      end
      3'd4: begin
        e.err = (imm[11:0] != 12'd0);
        e.instr[31:12] = imm[31:12];
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // The immediate extender: decoding an encoded word must give back the original value.
  function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'd0: return {{20{i[31]}}, i[31:20]};
      3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {i[31:12], 12'd0};
    endcase
  endfunction

  function automatic logic [31:0] legalImm(input logic [2:0] src);
    int v;
    case (src)
      3'd0, 3'd1: v = int'($urandom_range(0, 4095)) - 2048;
      3'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      3'd3:       v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      3'd4:       v = int'($urandom & 32'hFFFF_F000);
      default:    v = int'($urandom);
    endcase
    return 32'(v);
  endfunction

  task automatic applyStimulus(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base);
    bit accepted = 0;
    in_valid = 1'b1;
    in_imm_src = src;
    in_imm = imm;
    in_base = base;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(src, imm, base));
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 2000 && sb.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput("drain", 32'(sb.size()), 32'd0);
    checkOutput("err_count_idle", 32'(err_count), 32'(modelCnt));
  endtask

  always @(posedge clk) begin
    #1;
    if (randReady) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops one expectation per output transfer and watches stalled outputs.
  bit          heldValid = 0;
  logic [31:0] heldInstr;
  logic        heldErr;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      heldValid = 0;
    end else begin
      if (heldValid) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_instr", out_instr, heldInstr);
        checkOutput("stall_err", 32'(out_err), 32'(heldErr));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", out_instr, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          checkOutput("instr", out_instr, e.instr);
          checkOutput("err", 32'(out_err), 32'(e.err));
          checkOutput("err_count", 32'(err_count), 32'(modelCnt));
          if (!e.err) checkOutput("roundtrip", extend(out_instr, e.src), e.imm);
          if (e.err && modelCnt != CNT_MAX) modelCnt = modelCnt + 1'b1;
        end
      end
      heldValid = out_valid && !out_ready;
      heldInstr = out_instr;
      heldErr = out_err;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] src;
    reset = 1'b0;
    in_valid = 1'b0;
    in_imm_src = '0;
    in_imm = '0;
    in_base = '0;
    out_ready = 1'b1;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_instr", out_instr, 32'd0);
    checkOutput("reset_out_err", 32'(out_err), 32'd0);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    applyStimulus(3'd0, 32'hFFFF_FFFF, 32'h0000_0013);
    checkOutput("latency_1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_2", 32'(out_valid), 32'd1);
    waitDrain();

    applyStimulus(3'd2, 32'h0000_0FFE, 32'h0000_0063);
    applyStimulus(3'd2, 32'h0000_0FFF, 32'h0000_0063);
    applyStimulus(3'd3, 32'h0010_0000, 32'h0000_006F);
    applyStimulus(3'd3, 32'hFFF0_0000, 32'h0000_006F);
    applyStimulus(3'd4, 32'h1234_5000, 32'h0000_00B7);
    applyStimulus(3'd4, 32'h1234_5001, 32'h0000_00B7);
    applyStimulus(3'd0, 32'd2047, 32'h0000_0013);
    applyStimulus(3'd0, 32'd2048, 32'h0000_0013);
    applyStimulus(3'd1, 32'hFFFF_F800, 32'h0000_0023);
    applyStimulus(3'd1, 32'hFFFF_F7FF, 32'h0000_0023);
    applyStimulus(3'd2, 32'hFFFF_F000, 32'h0000_0063);
    applyStimulus(3'd2, 32'h0000_1000, 32'h0000_0063);
    applyStimulus(3'd3, 32'h000F_FFFE, 32'h0000_006F);
    applyStimulus(3'd3, 32'h0000_0002, 32'h0000_006F);
    applyStimulus(3'd5, 32'h0000_0000, 32'hDEAD_BEEF);
    applyStimulus(3'd7, 32'h0000_0004, 32'h1234_5678);
    waitDrain();

    out_ready = 1'b0;
    applyStimulus(3'd0, 32'd5, 32'h0000_0093);
    applyStimulus(3'd1, 32'd6, 32'h0000_00A3);
    in_valid = 1'b1;
    in_imm_src = 3'd4;
    in_imm = 32'hABCD_E000;
    in_base = 32'h0000_0037;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(3'd4, 32'hABCD_E000, 32'h0000_0037);
    waitDrain();

    for (int n = 0; n < 260; n++) begin
      src = 3'($urandom_range(5, 7));
      applyStimulus(src, $urandom, $urandom);
    end
    waitDrain();

    out_ready = 1'b0;
    applyStimulus(3'd6, 32'd1, 32'd2);
    applyStimulus(3'd0, 32'd3, 32'd4);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_err_count", 32'(err_count), 32'd0);
    checkOutput("midreset_out_instr", out_instr, 32'd0);
    sb.delete();
    modelCnt = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    randReady = 1;
    for (int n = 0; n < 1000; n++) begin
      src = 3'($urandom_range(0, 4));
      applyStimulus(src, legalImm(src), $urandom);
    end
    for (int n = 0; n < 300; n++) begin
      src = 3'($urandom_range(0, 7));
      applyStimulus(src, ($urandom_range(0, 1) == 0) ? $urandom : legalImm(src), $urandom);
    end
    randReady = 0;
    #2;
    out_ready = 1'b1;
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
